stream_pattern_producer: RTL and testbench
==========================================

# stream_pattern_producer

Parametrised valid/ready stream source generating configurable data patterns in bursts. Replaces the single-counter producer used in stream bring-up: it has generic data width, three pattern modes, burst framing with `last`, programmable inter-burst gaps, and back-to-back beats with no idle cycle between handshakes. It drives any stream consumer or FIFO under test and exposes beat and burst status for checkers.

## Interface
- `DATA_WIDTH`, 32: width of `data`, `step`, `seed`.
- `LEN_WIDTH`, 8: width of `burst_len` and the beat index.
- `GAP_WIDTH`, 8: width of `gap_len` and the gap counter.
- `CNT_WIDTH`, 32: width of `beat_count`.
- `LFSR_TAPS`, 32'h80200003: Galois LFSR feedback mask, `DATA_WIDTH` bits.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  run request, level-sensitive.
- `mode`  in  2  0 INCR, 1 LFSR, 2 CONST, 3 reserved (behaves as INCR).
- `step`  in  DATA_WIDTH  INCR increment.
- `seed`  in  DATA_WIDTH  first data value.
- `burst_len`  in  LEN_WIDTH  beats per burst; 0 means 2^LEN_WIDTH.
- `gap_len`  in  GAP_WIDTH  idle cycles between bursts.
- `vld`  out  1  data valid.
- `rdy`  in  1  consumer ready.
- `data`  out  DATA_WIDTH  current beat.
- `last`  out  1  final beat of burst.
- `beat_count`  out  CNT_WIDTH  total handshakes since reset, wraps.
- `burst_done`  out  1  one-cycle pulse per completed burst.
- `busy`  out  1  state is not IDLE.

## Operation
- States: IDLE, SEND, GAP.
- IDLE: `vld`=0. When `en`=1, capture `mode`, `step`, `seed`, `burst_len`, `gap_len` into shadow registers (config is sampled only here). Set `data`<=seed, or 1 if LFSR mode and seed==0. Clear the beat index and go to SEND.
- SEND: `vld`=1. `last` = (index == burst_len-1, mod 2^LEN_WIDTH). A handshake is `vld && rdy`.
  - Handshake on a non-last beat: `data`<=next(data), index+1, stay in SEND.
  - Handshake on the last beat: index<=0 and `data`<=next(data).
    - `en`=0: go to IDLE.
    - `en`=1 and gap==0: stay in SEND (back-to-back burst).
    - Otherwise: go to GAP.
- GAP: `vld`=0 for exactly gap_len cycles. Then go to SEND if `en`=1, else IDLE.
- The data sequence continues across bursts. Reseed happens only on the IDLE to SEND transition.
- next(): INCR gives data+step mod 2^DATA_WIDTH. LFSR gives lsb ? (data>>1)^LFSR_TAPS : data>>1. CONST gives data unchanged.
- Deasserting `en` mid-burst does not truncate. The burst completes, and `vld` is never withdrawn without a handshake.
- `beat_count` increments on every handshake and wraps to 0.

## Timing
- All outputs are registered.
- Reset: `vld`, `last`, `burst_done`, `busy` = 0; `data`, `beat_count` = 0; state IDLE. Reset is asynchronous and takes effect mid-burst.
- `en` high in IDLE at edge N gives `vld`=1 from edge N+1.
- While `vld`=1 && `rdy`=0, `data` and `last` hold stable.
- Sustained `rdy`=1 gives one beat per cycle, including across bursts when gap==0.
- `burst_done` is high for one cycle, the cycle after the last-beat handshake.
- `busy` is 1 in SEND and GAP.

## Structure
- Package `stream_gen_pkg`: mode encoding constants (MODE_INCR/LFSR/CONST), state enum (ST_IDLE/ST_SEND/ST_GAP).
- Sub-module `stream_gen_next`: combinational next-value for (mode, data, step, taps). It is reusable by the checker-side model.
- Top: FSM, shadow config, index/gap counters, status.

## Test plan
- Reset, then INCR, seed=0, step=1, burst_len=4, gap=0, `rdy`=1, `en` held -> data 0,1,2,3,4..., `last` on 3 and 7, no idle cycle, `burst_done` pulses 2 cycles.
- INCR, step=3, `rdy` toggling 1/0 every cycle -> data held while `rdy`=0; accepted 5,8,11 for seed=5. `beat_count` equals handshakes.
- DATA_WIDTH=8, LFSR_TAPS=8'hB8, seed=1, LFSR -> 01, B8, 5C, 2E. With seed=0 the first beat is 01.
- burst_len=2, gap_len=3 -> `vld` low exactly 3 cycles between bursts. `en` dropped during beat 1 -> beat 2 completes, then IDLE, `busy`=0.
- CONST, seed=32'hA5A5A5A5, burst_len=0, LEN_WIDTH=8 -> 256 identical beats, `last` on beat 256 only. INCR wrap: seed=32'hFFFFFFFE, step=1 -> FE, FF, 0.
- `rst` asserted mid-burst with `vld`=1, `rdy`=0 -> `vld`, `data`, `beat_count` go to 0 immediately. After `rst` release, sequence restarts from seed.

Source files
------------

// File: rtl/stream_pattern_producer_pkg.sv
// Shared encodings for the stream pattern producer: pattern modes and FSM states.
package stream_gen_pkg;

  localparam logic [1:0] MODE_INCR  = 2'd0;
  localparam logic [1:0] MODE_LFSR  = 2'd1;
  localparam logic [1:0] MODE_CONST = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/stream_pattern_producer_if.sv
// Valid/ready stream bundle carrying data and burst framing.
interface stream_pattern_producer_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic                  vld;
  logic                  rdy;
  logic [DATA_WIDTH-1:0] data;
  logic                  last;

  modport master (output vld, output data, output last, input rdy);
  modport slave  (input vld, input data, input last, output rdy);

endinterface

// File: rtl/stream_pattern_producer_next.sv
// Combinational next-beat generator; shared between the producer and checker-side models.
module stream_gen_next
  import stream_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [DATA_WIDTH-1:0] step,
  input  logic [DATA_WIDTH-1:0] taps,
  output logic [DATA_WIDTH-1:0] nxt
);

  always_comb begin
    nxt = data + step;
    case (mode)
      MODE_LFSR:  nxt = data[0] ? ((data >> 1) ^ taps) : (data >> 1);
      MODE_CONST: nxt = data;
      default:    nxt = data + step;
    endcase
  end

endmodule

// File: rtl/stream_pattern_producer.sv
// Burst-framed valid/ready pattern source with shadowed configuration and beat/burst status.
//
// state   | meaning
// IDLE    | no traffic; samples config and seed when en is high
// SEND    | vld high, beats advance on each handshake
// GAP     | vld low for gap_len cycles between bursts
module stream_pattern_producer
  import stream_gen_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    LEN_WIDTH  = 8,
  parameter int                    GAP_WIDTH  = 8,
  parameter int                    CNT_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = 32'h80200003
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] step,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic [GAP_WIDTH-1:0]  gap_len,
  stream_pattern_producer_if.master strm,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic                  burst_done,
  output logic                  busy
);

  state_t                state_q, state_nxt;
  logic [1:0]            mode_q, mode_nxt;
  logic [DATA_WIDTH-1:0] step_q, step_nxt;
  logic [LEN_WIDTH-1:0]  blen_q, blen_nxt;
  logic [GAP_WIDTH-1:0]  glen_q, glen_nxt;
  logic [LEN_WIDTH-1:0]  idx_q, idx_nxt;
  logic [GAP_WIDTH-1:0]  gap_cnt_q, gap_cnt_nxt;
  logic [DATA_WIDTH-1:0] data_q, data_nxt, data_gen;
  logic                  vld_q, last_q;
  logic                  done_nxt;
  logic                  hs;
  logic [DATA_WIDTH-1:0] seed_first;

  assign strm.vld  = vld_q;
  assign strm.data = data_q;
  assign strm.last = last_q;

  assign hs = vld_q && strm.rdy;

  // LFSR mode cannot start from zero or it would lock up
  assign seed_first = ((mode == MODE_LFSR) && (seed == '0)) ? DATA_WIDTH'(1) : seed;

  stream_gen_next #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_next (
    .mode (mode_q),
    .data (data_q),
    .step (step_q),
    .taps (LFSR_TAPS),
    .nxt  (data_gen)
  );

  always_comb begin
    state_nxt   = state_q;
    mode_nxt    = mode_q;
    step_nxt    = step_q;
    blen_nxt    = blen_q;
    glen_nxt    = glen_q;
    idx_nxt     = idx_q;
    gap_cnt_nxt = gap_cnt_q;
    data_nxt    = data_q;
    done_nxt    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          mode_nxt  = mode;
          step_nxt  = step;
          blen_nxt  = burst_len;
          glen_nxt  = gap_len;
          data_nxt  = seed_first;
          idx_nxt   = '0;
          state_nxt = ST_SEND;
        end
      end

      ST_SEND: begin
        if (hs) begin
          data_nxt = data_gen;
          if (last_q) begin
            idx_nxt  = '0;
            done_nxt = 1'b1;
            if (!en) begin
              state_nxt = ST_IDLE;
            end else if (glen_q == '0) begin
              state_nxt = ST_SEND;
            end else begin
              gap_cnt_nxt = glen_q - GAP_WIDTH'(1);
              state_nxt   = ST_GAP;
            end
          end else begin
            idx_nxt = idx_q + LEN_WIDTH'(1);
          end
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_nxt = en ? ST_SEND : ST_IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt_q - GAP_WIDTH'(1);
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_INCR;
      step_q     <= '0;
      blen_q     <= '0;
      glen_q     <= '0;
      idx_q      <= '0;
      gap_cnt_q  <= '0;
      data_q     <= '0;
      vld_q      <= 1'b0;
      last_q     <= 1'b0;
      burst_done <= 1'b0;
      busy       <= 1'b0;
      beat_count <= '0;
    end else begin
      state_q    <= state_nxt;
      mode_q     <= mode_nxt;
      step_q     <= step_nxt;
      blen_q     <= blen_nxt;
      glen_q     <= glen_nxt;
      idx_q      <= idx_nxt;
      gap_cnt_q  <= gap_cnt_nxt;
      data_q     <= data_nxt;
      vld_q      <= (state_nxt == ST_SEND);
      // burst_len of 0 wraps to all-ones, giving a full 2^LEN_WIDTH burst
      last_q     <= (state_nxt == ST_SEND) && (idx_nxt == (blen_nxt - LEN_WIDTH'(1)));
      burst_done <= done_nxt;
      busy       <= (state_nxt != ST_IDLE);
      if (hs) begin
        beat_count <= beat_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_stream_pattern_producer.sv
// Directed bench for stream_pattern_producer: per-cycle vector table plus hand sequences.
module tb_stream_pattern_producer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        en = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] step = '0, seed = '0;
  logic [7:0]  blen = '0, glen = '0;
  logic [31:0] cnt;
  logic        done, busy;
  stream_pattern_producer_if #(.DATA_WIDTH(32)) s32 ();

  stream_pattern_producer dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .step(step), .seed(seed),
    .burst_len(blen), .gap_len(glen), .strm(s32.master),
    .beat_count(cnt), .burst_done(done), .busy(busy)
  );

  // 8-bit LFSR instance
  logic        en8 = 1'b0;
  logic [1:0]  mode8 = 2'd1;
  logic [7:0]  step8 = '0, seed8 = '0;
  logic [7:0]  blen8 = 8'd4, glen8 = '0;
  logic [31:0] cnt8;
  logic        done8, busy8;
  stream_pattern_producer_if #(.DATA_WIDTH(8)) s8 ();

  stream_pattern_producer #(.DATA_WIDTH(8), .LFSR_TAPS(8'hB8)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .mode(mode8), .step(step8), .seed(seed8),
    .burst_len(blen8), .gap_len(glen8), .strm(s8.master),
    .beat_count(cnt8), .burst_done(done8), .busy(busy8)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        en, rdy;
    logic [1:0]  mode;
    logic [31:0] step, seed;
    logic [7:0]  blen, glen;
    logic        vld;
    logic [31:0] data;
    logic        last, done, busy;
    logic [31:0] cnt;
  } vec_t;

  function automatic vec_t mk(logic e, logic r, logic [1:0] m, logic [31:0] st, logic [31:0] sd,
                              logic [7:0] bl, logic [7:0] gl, logic v, logic [31:0] d,
                              logic l, logic dn, logic b, logic [31:0] c);
    vec_t t;
    t.en = e; t.rdy = r; t.mode = m; t.step = st; t.seed = sd; t.blen = bl; t.glen = gl;
    t.vld = v; t.data = d; t.last = l; t.done = dn; t.busy = b; t.cnt = c;
    return t;
  endfunction

  localparam int NV = 35;
  vec_t vecs [NV];

  initial begin
    int  n_last, last_pos, bad_data;

    // INCR seed 0 step 1, 4-beat bursts back to back, then en dropped mid-burst
    vecs[0]  = mk(1,1,0,1,0,4,0, 1,32'd0, 0,0,1,0);
    vecs[1]  = mk(1,1,0,1,0,4,0, 1,32'd1, 0,0,1,1);
    vecs[2]  = mk(1,1,0,1,0,4,0, 1,32'd2, 0,0,1,2);
    vecs[3]  = mk(1,1,0,1,0,4,0, 1,32'd3, 1,0,1,3);
    vecs[4]  = mk(1,1,0,1,0,4,0, 1,32'd4, 0,1,1,4);
    vecs[5]  = mk(1,1,0,1,0,4,0, 1,32'd5, 0,0,1,5);
    vecs[6]  = mk(1,1,0,1,0,4,0, 1,32'd6, 0,0,1,6);
    vecs[7]  = mk(1,1,0,1,0,4,0, 1,32'd7, 1,0,1,7);
    vecs[8]  = mk(1,1,0,1,0,4,0, 1,32'd8, 0,1,1,8);
    vecs[9]  = mk(0,1,0,1,0,4,0, 1,32'd9, 0,0,1,9);
    vecs[10] = mk(0,1,0,1,0,4,0, 1,32'd10,0,0,1,10);
    vecs[11] = mk(0,1,0,1,0,4,0, 1,32'd11,1,0,1,11);
    vecs[12] = mk(0,1,0,1,0,4,0, 0,32'd12,0,1,0,12);
    // INCR seed 5 step 3 with rdy toggling: data and last hold while stalled
    vecs[13] = mk(1,0,0,3,5,4,0, 1,32'd5, 0,0,1,12);
    vecs[14] = mk(1,1,0,3,5,4,0, 1,32'd8, 0,0,1,13);
    vecs[15] = mk(1,0,0,3,5,4,0, 1,32'd8, 0,0,1,13);
    vecs[16] = mk(1,1,0,3,5,4,0, 1,32'd11,0,0,1,14);
    vecs[17] = mk(1,0,0,3,5,4,0, 1,32'd11,0,0,1,14);
    vecs[18] = mk(1,1,0,3,5,4,0, 1,32'd14,1,0,1,15);
    vecs[19] = mk(1,0,0,3,5,4,0, 1,32'd14,1,0,1,15);
    vecs[20] = mk(0,1,0,3,5,4,0, 0,32'd17,0,1,0,16);
    // reserved mode (INCR), burst 2, gap 3; en dropped during the first beat
    vecs[21] = mk(1,1,3,1,100,2,3, 1,32'd100,0,0,1,16);
    vecs[22] = mk(1,1,3,1,100,2,3, 1,32'd101,1,0,1,17);
    vecs[23] = mk(1,1,3,1,100,2,3, 0,32'd102,0,1,1,18);
    vecs[24] = mk(1,1,3,1,100,2,3, 0,32'd102,0,0,1,18);
    vecs[25] = mk(1,1,3,1,100,2,3, 0,32'd102,0,0,1,18);
    vecs[26] = mk(1,1,3,1,100,2,3, 1,32'd102,0,0,1,18);
    vecs[27] = mk(0,1,3,1,100,2,3, 1,32'd103,1,0,1,19);
    vecs[28] = mk(0,1,3,1,100,2,3, 0,32'd104,0,1,0,20);
    vecs[29] = mk(0,1,3,1,100,2,3, 0,32'd104,0,0,0,20);
    // INCR wrap through zero
    vecs[30] = mk(1,1,0,1,32'hFFFFFFFE,4,0, 1,32'hFFFFFFFE,0,0,1,20);
    vecs[31] = mk(1,1,0,1,32'hFFFFFFFE,4,0, 1,32'hFFFFFFFF,0,0,1,21);
    vecs[32] = mk(1,1,0,1,32'hFFFFFFFE,4,0, 1,32'h00000000,0,0,1,22);
    vecs[33] = mk(0,1,0,1,32'hFFFFFFFE,4,0, 1,32'h00000001,1,0,1,23);
    vecs[34] = mk(0,1,0,1,32'hFFFFFFFE,4,0, 0,32'h00000002,0,1,0,24);

    s32.rdy = 1'b0;
    s8.rdy  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst vld",  {31'd0, s32.vld}, 0);
    chk("rst last", {31'd0, s32.last}, 0);
    chk("rst data", s32.data, 0);
    chk("rst cnt",  cnt, 0);
    chk("rst busy", {31'd0, busy}, 0);
    chk("rst done", {31'd0, done}, 0);
    chk("rst vld8", {31'd0, s8.vld}, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      en = vecs[i].en; s32.rdy = vecs[i].rdy; mode = vecs[i].mode;
      step = vecs[i].step; seed = vecs[i].seed; blen = vecs[i].blen; glen = vecs[i].glen;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d vld", i),  {31'd0, s32.vld},  {31'd0, vecs[i].vld});
      chk($sformatf("vec%0d data", i), s32.data,          vecs[i].data);
      chk($sformatf("vec%0d last", i), {31'd0, s32.last}, {31'd0, vecs[i].last});
      chk($sformatf("vec%0d done", i), {31'd0, done},     {31'd0, vecs[i].done});
      chk($sformatf("vec%0d busy", i), {31'd0, busy},     {31'd0, vecs[i].busy});
      chk($sformatf("vec%0d cnt", i),  cnt,               vecs[i].cnt);
    end

    // CONST with burst_len 0: 256 identical beats, last only on the final one
    mode = 2'd2; seed = 32'hA5A5A5A5; blen = 8'd0; glen = 8'd0; s32.rdy = 1'b1; en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    n_last = 0; last_pos = -1; bad_data = 0;
    for (int i = 0; i < 256; i++) begin
      if (!s32.vld || s32.data !== 32'hA5A5A5A5) bad_data++;
      if (s32.last) begin
        n_last++;
        last_pos = i;
      end
      @(posedge clk);
      #1;
    end
    chk("const bad beats", bad_data, 0);
    chk("const last count", n_last, 1);
    chk("const last pos", last_pos, 255);
    chk("const end vld", {31'd0, s32.vld}, 0);
    chk("const end done", {31'd0, done}, 1);
    chk("const end cnt", cnt, 280);

    // 8-bit LFSR, taps B8: seed 1 then seed 0
    mode8 = 2'd1; seed8 = 8'h01; blen8 = 8'd4; glen8 = 8'd0; s8.rdy = 1'b1; en8 = 1'b1;
    @(posedge clk); #1; chk("lfsr b0", {24'd0, s8.data}, 32'h01);
    @(posedge clk); #1; chk("lfsr b1", {24'd0, s8.data}, 32'hB8);
    @(posedge clk); #1; chk("lfsr b2", {24'd0, s8.data}, 32'h5C);
    en8 = 1'b0;
    @(posedge clk); #1; chk("lfsr b3", {24'd0, s8.data}, 32'h2E);
    chk("lfsr b3 last", {31'd0, s8.last}, 1);
    @(posedge clk); #1; chk("lfsr idle vld", {31'd0, s8.vld}, 0);
    chk("lfsr cnt", cnt8, 4);
    seed8 = 8'h00; en8 = 1'b1;
    @(posedge clk); #1; chk("lfsr seed0 first", {24'd0, s8.data}, 32'h01);
    en8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("lfsr seed0 drained", {31'd0, s8.vld}, 0);
    chk("lfsr cnt2", cnt8, 8);

    // asynchronous reset while stalled mid-burst, then restart from seed
    mode = 2'd0; seed = 32'd7; step = 32'd2; blen = 8'd4; glen = 8'd0; s32.rdy = 1'b0; en = 1'b1;
    @(posedge clk); #1; chk("ar first", s32.data, 7);
    s32.rdy = 1'b1;
    @(posedge clk); #1; chk("ar second", s32.data, 9);
    chk("ar cnt", cnt, 281);
    s32.rdy = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("ar vld", {31'd0, s32.vld}, 0);
    chk("ar data", s32.data, 0);
    chk("ar cnt0", cnt, 0);
    chk("ar busy", {31'd0, busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ar restart vld", {31'd0, s32.vld}, 1);
    chk("ar restart data", s32.data, 7);
    s32.rdy = 1'b1;
    @(posedge clk); #1;
    chk("ar restart next", s32.data, 9);
    chk("ar restart cnt", cnt, 1);
    en = 1'b0;
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
